// File: rtl/gray_checker.sv
// Monitors a Gray-code counter and its sticky overflow flag. It tracks the binary value
// and counts wraps. Any illegal step or overflow edge latches a sticky error until reset.
module gray_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  Gray,
  input  logic              Overflow,
  output logic [WIDTH-1:0]  Bin,
  output logic              Valid,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              Error
);

  typedef enum logic [1:0] {IDLE, TRACK, FAIL} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic               valid_q;
  logic               err_q;
  logic [WRAP_W-1:0]  wrap_q;
  logic               ovf_q;
  logic               rise_pend_q;
  logic               fall_pend_q;

  logic [WIDTH-1:0]   conv;
  logic [WIDTH-1:0]   inc;
  logic               stall, step, wrap;
  logic               ovf_rise, ovf_fall, rise_eff, fall_eff, viol;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    conv = '0;
    for (int i = 0; i < WIDTH; i++) conv[i] = ^(Gray >> i);
  end

  always_comb begin
    inc      = bin_q + WIDTH'(1);
    stall    = (conv == bin_q);
    step     = (conv == inc);
    wrap     = step && (&bin_q);
    ovf_rise = Overflow & ~ovf_q;
    ovf_fall = ~Overflow & ovf_q;
    // Edges seen while disabled are held pending until the next enabled sample.
    rise_eff = ovf_rise | rise_pend_q;
    fall_eff = ovf_fall | fall_pend_q;
    viol     = !(stall || step) || (rise_eff && !wrap) || fall_eff;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= '0;
      ovf_q       <= 1'b0;
      rise_pend_q <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      ovf_q <= Overflow;
      if (!En) begin
        rise_pend_q <= rise_pend_q | ovf_rise;
        fall_pend_q <= fall_pend_q | ovf_fall;
      end else begin
        rise_pend_q <= 1'b0;
        fall_pend_q <= 1'b0;
        case (state_q)
          IDLE: begin
            bin_q   <= conv;
            valid_q <= 1'b1;
            state_q <= TRACK;
          end
          TRACK: begin
            if (viol) begin
              err_q   <= 1'b1;
              state_q <= FAIL;
            end else if (step) begin
              bin_q <= conv;
              if (wrap && (wrap_q != '1)) wrap_q <= wrap_q + WRAP_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Bin     = bin_q;
  assign Valid   = valid_q;
  assign WrapCnt = wrap_q;
  assign Error   = err_q;

endmodule

// File: tb/tb_gray_checker.sv
// Directed bench for gray_checker (WIDTH=3, WRAP_W=8) with hand-computed expectations.
module tb_gray_checker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic       Overflow = 1'b0;
  logic [2:0] Bin;
  logic       Valid;
  logic [7:0] WrapCnt;
  logic       Error;

  int vectors = 0;
  int miscompares = 0;

  // Gray codes for binary 0..7
  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_checker #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Overflow(Overflow),
    .Bin(Bin), .Valid(Valid), .WrapCnt(WrapCnt), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; En = 1'b0; Overflow = 1'b0; Gray = 3'b000;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; En = 1'b1; Gray = 3'b101; Overflow = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({Bin, Valid, WrapCnt, Error} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] got bin=%0d v=%0b w=%0d e=%0b want all 0", c, Bin, Valid, WrapCnt, Error);
      end
    end
    Reset = 1'b1; En = 1'b0; Overflow = 1'b0; Gray = 3'b000;
    tick();
    vectors++;
    if ({Bin, Valid, WrapCnt, Error} !== 13'd0) begin
      miscompares++;
      $display("FAIL idle_no_en got bin=%0d v=%0b w=%0d e=%0b want all 0", Bin, Valid, WrapCnt, Error);
    end
  endtask

  task automatic test_sequence();
    En = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Gray = gseq[i];
      tick();
      vectors++;
      if ({Valid, Error, WrapCnt, Bin} !== {1'b1, 1'b0, 8'd0, 3'(i)}) begin
        miscompares++;
        $display("FAIL seq[%0d] got bin=%0d v=%0b w=%0d e=%0b want bin=%0d v=1 w=0 e=0", i, Bin, Valid, WrapCnt, Error, i);
      end
    end
  endtask

  task automatic test_wrap();
    Gray = 3'b000; Overflow = 1'b1;
    tick();
    vectors++;
    if ({Error, WrapCnt, Bin} !== {1'b0, 8'd1, 3'd0}) begin
      miscompares++;
      $display("FAIL wrap_first got bin=%0d w=%0d e=%0b want bin=0 w=1 e=0", Bin, WrapCnt, Error);
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 1; i <= 8; i++) begin
        Gray = gseq[i % 8];
        tick();
      end
      if (c == 253 || c == 299) begin
        vectors++;
        if ({Error, WrapCnt, Bin} !== {1'b0, 8'd255, 3'd0}) begin
          miscompares++;
          $display("FAIL wrap_sat[%0d] got bin=%0d w=%0d e=%0b want bin=0 w=255 e=0", c, Bin, WrapCnt, Error);
        end
      end
    end
  endtask

  task automatic test_stall();
    Gray = 3'b000;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({Valid, Error, WrapCnt, Bin} !== {1'b1, 1'b0, 8'd255, 3'd0}) begin
        miscompares++;
        $display("FAIL stall[%0d] got bin=%0d w=%0d e=%0b want bin=0 w=255 e=0", c, Bin, WrapCnt, Error);
      end
    end
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    En = 1'b1; Gray = 3'b000;
    tick();
    for (int c = 0; c < 4; c++) begin
      for (int i = 1; i <= 8; i++) begin
        Gray = gseq[i % 8];
        tick();
      end
    end
    vectors++;
    if ({Error, WrapCnt, Bin} !== {1'b0, 8'd4, 3'd0}) begin
      miscompares++;
      $display("FAIL four_wraps got bin=%0d w=%0d e=%0b want bin=0 w=4 e=0", Bin, WrapCnt, Error);
    end
    Reset = 1'b0; Gray = 3'b001;
    tick();
    vectors++;
    if ({Bin, Valid, WrapCnt, Error} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_track got bin=%0d v=%0b w=%0d e=%0b want all 0", Bin, Valid, WrapCnt, Error);
    end
    Reset = 1'b1; Gray = 3'b111;
    tick();
    vectors++;
    if ({Valid, Error, WrapCnt, Bin} !== {1'b1, 1'b0, 8'd0, 3'd5}) begin
      miscompares++;
      $display("FAIL recapture_track got bin=%0d v=%0b w=%0d e=%0b want bin=5 v=1 w=0 e=0", Bin, Valid, WrapCnt, Error);
    end
  endtask

  task automatic test_enable_hold();
    logic [2:0] junk [5] = '{3'b111, 3'b010, 3'b101, 3'b110, 3'b011};
    do_reset();
    En = 1'b1; Gray = 3'b000; tick();
    Gray = 3'b001; tick();
    En = 1'b0;
    for (int c = 0; c < 5; c++) begin
      Gray = junk[c];
      tick();
      vectors++;
      if ({Valid, Error, Bin} !== {1'b1, 1'b0, 3'd1}) begin
        miscompares++;
        $display("FAIL en_hold[%0d] got bin=%0d v=%0b e=%0b want bin=1 v=1 e=0", c, Bin, Valid, Error);
      end
    end
    En = 1'b1; Gray = 3'b011;
    tick();
    vectors++;
    if ({Error, Bin} !== {1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL en_resume got bin=%0d e=%0b want bin=2 e=0", Bin, Error);
    end
  endtask

  task automatic test_ovf_while_disabled();
    En = 1'b0; Overflow = 1'b1;
    tick();
    En = 1'b1; Gray = 3'b010;
    tick();
    vectors++;
    if ({Error, Bin} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL ovf_pending got bin=%0d e=%0b want bin=2 e=1", Bin, Error);
    end
  endtask

  task automatic test_seq_violation();
    do_reset();
    En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Gray = gseq[i];
      tick();
    end
    Gray = 3'b101;
    tick();
    vectors++;
    if ({Valid, Error, Bin} !== {1'b1, 1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL seq_viol got bin=%0d v=%0b e=%0b want bin=2 v=1 e=1", Bin, Valid, Error);
    end
    for (int c = 0; c < 3; c++) begin
      Gray = 3'b010; Overflow = ~Overflow;
      tick();
      vectors++;
      if ({Valid, Error, WrapCnt, Bin} !== {1'b1, 1'b1, 8'd0, 3'd2}) begin
        miscompares++;
        $display("FAIL fail_absorb[%0d] got bin=%0d v=%0b w=%0d e=%0b want bin=2 v=1 w=0 e=1", c, Bin, Valid, WrapCnt, Error);
      end
    end
  endtask

  task automatic test_reset_from_fail();
    Reset = 1'b0; En = 1'b1; Gray = 3'b011;
    tick();
    vectors++;
    if ({Bin, Valid, WrapCnt, Error} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_fail got bin=%0d v=%0b w=%0d e=%0b want all 0", Bin, Valid, WrapCnt, Error);
    end
    Reset = 1'b1; Overflow = 1'b0; Gray = 3'b111;
    tick();
    vectors++;
    if ({Valid, Error, WrapCnt, Bin} !== {1'b1, 1'b0, 8'd0, 3'd5}) begin
      miscompares++;
      $display("FAIL recapture_fail got bin=%0d v=%0b w=%0d e=%0b want bin=5 v=1 w=0 e=0", Bin, Valid, WrapCnt, Error);
    end
  endtask

  task automatic test_ovf_violation();
    do_reset();
    En = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Gray = gseq[i];
      tick();
    end
    Gray = 3'b110; Overflow = 1'b1;
    tick();
    vectors++;
    if ({Error, Bin} !== {1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL ovf_no_wrap got bin=%0d e=%0b want bin=3 e=1", Bin, Error);
    end
  endtask

  task automatic test_ovf_fall();
    do_reset();
    En = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Gray = gseq[i];
      tick();
    end
    Gray = 3'b000; Overflow = 1'b1;
    tick();
    Gray = 3'b001; Overflow = 1'b0;
    tick();
    vectors++;
    if ({Error, WrapCnt, Bin} !== {1'b1, 8'd1, 3'd0}) begin
      miscompares++;
      $display("FAIL ovf_fall got bin=%0d w=%0d e=%0b want bin=0 w=1 e=1", Bin, WrapCnt, Error);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_stall();
    test_reset_mid_track();
    test_enable_hold();
    test_ovf_while_disabled();
    test_seq_violation();
    test_reset_from_fail();
    test_ovf_violation();
    test_ovf_fall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
